// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Optional feature macro: STOPWATCH_CTRL_AUTOSTOP_EN (adds the OVFSTOP state
// and the 59:59.99 auto-stop comparator).
package stopwatch_pkg;

    // Default number of BCD digits: csec1, csec10, sec1, sec10, min1, min10.
    localparam int NDIG_DEFAULT = 6;

    // Last displayable count, 59:59.99, MSD in the top nibble.
    localparam logic [23:0] OVF_PATTERN = 24'h595999;

    // Controller state; the encoding is visible on the STATE port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_LAP     = 3'd3
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
        ,
        ST_OVFSTOP = 3'd4
`endif
    } sw_state_e;

endpackage

// File: rtl/sw_lap_latch.sv
// Lap capture register plus the display multiplexer. While hold is high the
// captured digits are shown; otherwise the live count passes straight through.
module sw_lap_latch
    import stopwatch_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              capture,
    input  logic              hold,
    input  logic [4*NDIG-1:0] DIG_IN,
    output logic [4*NDIG-1:0] DISP_OUT
);

    logic [4*NDIG-1:0] lap_q;

    // Snapshot the live count on a lap press; cleared by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lap_q <= '0;
        end else if (capture) begin
            lap_q <= DIG_IN;
        end
    end

    // Frozen lap value while holding, live digits otherwise.
    always_comb begin
        DISP_OUT = hold ? lap_q : DIG_IN;
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop, lap/reset, counter enable and clear.
// Optional feature macro: STOPWATCH_CTRL_AUTOSTOP_EN stops the count at
// 59:59.99 and parks the FSM in OVFSTOP until lap/reset is pressed.
// Without the macro the counter chain simply wraps to 00:00.00.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN10MS,
    input  logic              SS,
    input  logic              LR,
    input  logic [4*NDIG-1:0] DIG_IN,
    output logic              CNT_TICK,
    output logic              CNT_CLR,
    output logic [4*NDIG-1:0] DISP_OUT,
    output logic [2:0]        STATE,
    output logic              RUN_LED
);

    // Handshake note: SS, LR and EN10MS are single-cycle strobes with no
    // back-pressure; each is acted on in the cycle it is high. When SS and
    // LR coincide, SS is taken and LR is dropped.

    sw_state_e state, state_nx;
    logic      clr_nx;
    logic      cnt_clr_q;
    logic      capture;
    logic      counting;
    logic      ovf_hit;

    assign counting = (state == ST_RUN) || (state == ST_LAP);

`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
    localparam logic [4*NDIG-1:0] OVF_FULL = (4*NDIG)'(OVF_PATTERN);
    assign ovf_hit = counting && (DIG_IN == OVF_FULL);
`else
    assign ovf_hit = 1'b0;
`endif

    // State register and the registered one-cycle counter clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            cnt_clr_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt_clr_q <= clr_nx;
        end
    end

    // Next-state decode; SS is tested first so it always beats LR.
    always_comb begin
        state_nx = state;
        clr_nx   = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (SS) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (SS) begin
                    state_nx = ST_PAUSE;
                end else if (LR) begin
                    state_nx = ST_LAP;
                    capture  = 1'b1;
                end
            end
            ST_LAP: begin
                if (SS) begin
                    state_nx = ST_PAUSE;
                end else if (LR) begin
                    state_nx = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (SS) begin
                    state_nx = ST_RUN;
                end else if (LR) begin
                    state_nx = ST_IDLE;
                    clr_nx   = 1'b1;
                end
            end
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
            ST_OVFSTOP: begin
                if (LR) begin
                    state_nx = ST_IDLE;
                    clr_nx   = 1'b1;
                end
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
        // Reaching the last count overrides any button in the same cycle.
        if (ovf_hit) begin
            state_nx = ST_OVFSTOP;
            capture  = 1'b0;
        end
`endif
    end

    sw_lap_latch #(.NDIG(NDIG)) u_lap (
        .CLK      (CLK),
        .RST      (RST),
        .capture  (capture),
        .hold     (state == ST_LAP),
        .DIG_IN   (DIG_IN),
        .DISP_OUT (DISP_OUT)
    );

    assign CNT_TICK = EN10MS && counting && !ovf_hit;
    assign CNT_CLR  = cnt_clr_q;
    assign STATE    = state;
    assign RUN_LED  = counting;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a random
// walk of button presses, ticks and live counts against a behavioural model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam logic [23:0] LAST_COUNT = 24'h595999; // 59:59.99
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3, M_OVF = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN10MS = 1'b0;
    logic        SS = 1'b0;
    logic        LR = 1'b0;
    logic [23:0] DIG_IN = 24'h001111;
    logic        CNT_TICK;
    logic        CNT_CLR;
    logic [23:0] DISP_OUT;
    logic [2:0]  STATE;
    logic        RUN_LED;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_cnt = 0;
    bit cmp_en = 1'b0;

    // model state
    int          m_mode = M_IDLE;
    logic [23:0] m_lap = '0;
    bit          m_clr = 1'b0;

    stopwatch_ctrl #(.NDIG(6)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN10MS   (EN10MS),
        .SS       (SS),
        .LR       (LR),
        .DIG_IN   (DIG_IN),
        .CNT_TICK (CNT_TICK),
        .CNT_CLR  (CNT_CLR),
        .DISP_OUT (DISP_OUT),
        .STATE    (STATE),
        .RUN_LED  (RUN_LED)
    );

    // clock / reset block
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] code(input int m);
        case (m)
            M_IDLE:  return ST_IDLE;
            M_RUN:   return ST_RUN;
            M_PAUSE: return ST_PAUSE;
            M_LAP:   return ST_LAP;
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
            default: return ST_OVFSTOP;
`else
            default: return 3'd7;
`endif
        endcase
    endfunction

    function automatic bit autostop_match(input int m, input logic [23:0] d);
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
        return (m == M_RUN || m == M_LAP) && (d == LAST_COUNT);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [23:0] rand_dig();
        logic [23:0] d;
        d[3:0]   = 4'($urandom_range(9));
        d[7:4]   = 4'($urandom_range(9));
        d[11:8]  = 4'($urandom_range(9));
        d[15:12] = 4'($urandom_range(5));
        d[19:16] = 4'($urandom_range(9));
        d[23:20] = 4'($urandom_range(5));
        return d;
    endfunction

    // Behavioural model: button rules of the stopwatch, advanced per edge.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_mode = M_IDLE;
            m_lap  = '0;
            m_clr  = 1'b0;
        end else begin
            m_clr = 1'b0;
            if (autostop_match(m_mode, DIG_IN)) begin
                m_mode = M_OVF;
            end else if (SS) begin
                if (m_mode == M_IDLE || m_mode == M_PAUSE) m_mode = M_RUN;
                else if (m_mode == M_RUN || m_mode == M_LAP) m_mode = M_PAUSE;
            end else if (LR) begin
                if (m_mode == M_RUN) begin
                    m_mode = M_LAP;
                    m_lap  = DIG_IN;
                end else if (m_mode == M_LAP) begin
                    m_mode = M_RUN;
                end else if (m_mode == M_PAUSE || m_mode == M_OVF) begin
                    m_mode = M_IDLE;
                    m_clr  = 1'b1;
                end
            end
        end
    end

    // Scoreboard compare on every falling edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            bit cnt_on;
            cnt_on = (m_mode == M_RUN) || (m_mode == M_LAP);
            check("state", 32'(STATE), 32'(code(m_mode)));
            check("cnt_tick", 32'(CNT_TICK),
                  32'(EN10MS && cnt_on && !autostop_match(m_mode, DIG_IN)));
            check("cnt_clr", 32'(CNT_CLR), 32'(m_clr));
            check("disp_out", 32'(DISP_OUT), 32'((m_mode == M_LAP) ? m_lap : DIG_IN));
            check("run_led", 32'(RUN_LED), 32'(cnt_on));
        end
    end

    // Driver: present strobes for one cycle, count ticks seen meanwhile.
    task automatic cyc(input logic ss, input logic lr, input logic en);
        SS = ss;
        LR = lr;
        EN10MS = en;
        #2;
        if (CNT_TICK) tick_cnt++;
        @(posedge CLK);
        #1;
        SS = 1'b0;
        LR = 1'b0;
        EN10MS = 1'b0;
    endtask

    initial begin
        // reset state, with EN10MS high to prove ticks are gated
        RST = 1'b0;
        EN10MS = 1'b1;
        repeat (3) @(posedge CLK);
        #4;
        check("rst_state", 32'(STATE), 32'(ST_IDLE));
        check("rst_cnt_clr", 32'(CNT_CLR), 32'd0);
        check("rst_run_led", 32'(RUN_LED), 32'd0);
        check("rst_cnt_tick", 32'(CNT_TICK), 32'd0);
        check("rst_disp", 32'(DISP_OUT), 32'h001111);
        EN10MS = 1'b0;
        RST = 1'b1;
        cmp_en = 1'b1;
        @(posedge CLK);
        #1;

        // start, 100 ticks, stop
        tick_cnt = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 200; i++) cyc(0, 0, (i % 2) == 0);
        cyc(1, 0, 0);
        #3;
        check("tick_count", 32'(tick_cnt), 32'd100);
        check("pause_state", 32'(STATE), 32'(ST_PAUSE));
        check("pause_led", 32'(RUN_LED), 32'd0);

        // PAUSE + LR -> clear pulse one cycle after, then nothing more
        cyc(0, 1, 0);
        #3;
        check("clr_pulse", 32'(CNT_CLR), 32'd1);
        check("clr_idle", 32'(STATE), 32'(ST_IDLE));
        cyc(0, 0, 0);
        #3;
        check("clr_width", 32'(CNT_CLR), 32'd0);
        cyc(0, 1, 0);
        #3;
        check("idle_lr_noclr", 32'(CNT_CLR), 32'd0);
        check("idle_lr_state", 32'(STATE), 32'(ST_IDLE));

        // lap hold and release
        cyc(1, 0, 0);
        DIG_IN = 24'h001234;
        cyc(0, 1, 0);
        DIG_IN = 24'h001500;
        #3;
        check("lap_hold", 32'(DISP_OUT), 32'h001234);
        check("lap_state", 32'(STATE), 32'(ST_LAP));
        cyc(0, 1, 0);
        #3;
        check("lap_release", 32'(DISP_OUT), 32'h001500);
        check("lap_back_run", 32'(STATE), 32'(ST_RUN));

        // SS and LR together in RUN: SS wins
        DIG_IN = 24'h002222;
        cyc(1, 1, 0);
        #3;
        check("both_state", 32'(STATE), 32'(ST_PAUSE));
        check("both_disp", 32'(DISP_OUT), 32'h002222);
        check("both_noclr", 32'(CNT_CLR), 32'd0);

        // last count reached while running
        cyc(1, 0, 0);
        DIG_IN = LAST_COUNT;
        EN10MS = 1'b1;
        #2;
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
        check("ovf_tick_low", 32'(CNT_TICK), 32'd0);
        @(posedge CLK);
        #1;
        EN10MS = 1'b0;
        #3;
        check("ovf_state", 32'(STATE), 32'(ST_OVFSTOP));
        check("ovf_disp", 32'(DISP_OUT), 32'(LAST_COUNT));
        cyc(1, 0, 0);
        #3;
        check("ovf_ss_ignored", 32'(STATE), 32'(ST_OVFSTOP));
        cyc(0, 1, 0);
        #3;
        check("ovf_clr", 32'(CNT_CLR), 32'd1);
        check("ovf_to_idle", 32'(STATE), 32'(ST_IDLE));
`else
        check("wrap_tick_on", 32'(CNT_TICK), 32'd1);
        @(posedge CLK);
        #1;
        EN10MS = 1'b0;
        #3;
        check("wrap_state", 32'(STATE), 32'(ST_RUN));
        DIG_IN = 24'h000000;
        cyc(0, 0, 1);
        #3;
        check("wrap_still_run", 32'(STATE), 32'(ST_RUN));
        cyc(1, 0, 0);
`endif

        // asynchronous reset during LAP
        cyc(1, 0, 0);
        DIG_IN = 24'h000777;
        cyc(0, 1, 0);
        DIG_IN = 24'h000800;
        #1;
        check("pre_rst_hold", 32'(DISP_OUT), 32'h000777);
        #1;
        RST = 1'b0;
        #1;
        check("async_rst_state", 32'(STATE), 32'(ST_IDLE));
        check("async_rst_disp", 32'(DISP_OUT), 32'h000800);
        check("async_rst_led", 32'(RUN_LED), 32'd0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        RST = 1'b1;

        // random walk
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) DIG_IN = rand_dig();
            if ($urandom_range(39) == 0) DIG_IN = LAST_COUNT;
            if ($urandom_range(299) == 0) RST = 1'b0;
            cyc($urandom_range(7) == 0, $urandom_range(5) == 0, $urandom_range(1) == 0);
            RST = 1'b1;
        end

        cmp_en = 1'b0;
        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // overall time guard
    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, required completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The module SHALL have parameter NDIG, default 6, giving the number of BCD display digits (csec1, csec10, sec1, sec10, min1, min10 order, LSD first).
REQ-002 CLK  input  1  system clock, 50 MHz, all state on rising edge.
REQ-003 RST  input  1  asynchronous active-low reset.
REQ-004 EN10MS  input  1  one-cycle 10 ms tick from the tick generator.
REQ-005 SS  input  1  one-cycle debounced start/stop press.
REQ-006 LR  input  1  one-cycle debounced lap/reset press.
REQ-007 DIG_IN  input  4*NDIG  live BCD count from the counter chain.
REQ-008 CNT_TICK  output  1  count enable to the counter chain.
REQ-009 CNT_CLR  output  1  one-cycle synchronous clear to the counter chain.
REQ-010 DISP_OUT  output  4*NDIG  BCD digits to the 7-segment decoders.
REQ-011 STATE  output  3  current FSM state encoding.
REQ-012 RUN_LED  output  1  high while counting (RUN or LAP).

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSE, LAP, and OVFSTOP (OVFSTOP only under the macro).
REQ-014 IDLE: SS goes to RUN; LR is ignored.
REQ-015 RUN: SS goes to PAUSE; LR goes to LAP and captures DIG_IN into the lap register on the same edge.
REQ-016 LAP: LR goes to RUN (display released); SS goes to PAUSE (display released).
REQ-017 PAUSE: SS goes to RUN; LR goes to IDLE and asserts CNT_CLR for exactly the following cycle.
REQ-018 If SS and LR are high in the same cycle, SS SHALL win and LR SHALL be discarded.
REQ-019 CNT_TICK SHALL equal EN10MS AND (state is RUN or LAP), combinationally, with zero latency.
REQ-020 In the cycle where SS takes the FSM out of RUN or LAP, CNT_TICK SHALL already be low on the next EN10MS.
REQ-021 DISP_OUT SHALL show the lap register in LAP, and DIG_IN combinationally in every other state.
REQ-022 CNT_CLR SHALL be registered, one cycle wide, and never asserted outside the PAUSE->IDLE or OVFSTOP->IDLE transition.
REQ-023 Without the macro, the count SHALL wrap 59:59.99 -> 00:00.00 and the FSM SHALL remain in RUN or LAP.

Reset
REQ-024 When RST is low, the FSM SHALL be in IDLE, CNT_CLR 0, lap register all zeros, RUN_LED 0, CNT_TICK 0, DISP_OUT = DIG_IN.
REQ-025 If reset is applied mid-LAP, the lap hold SHALL be lost immediately (asynchronously).
REQ-026 Reset SHALL NOT generate a CNT_CLR pulse; the counter chain shares RST.

Configuration
REQ-027 With STOPWATCH_CTRL_AUTOSTOP_EN defined, the module SHALL compare DIG_IN to 59:59.99 in RUN or LAP.
REQ-028 On a match, CNT_TICK SHALL be forced low and the FSM SHALL go to OVFSTOP; the display SHALL show live digits, holding 59:59.99.
REQ-029 OVFSTOP: SS is ignored; LR goes to IDLE with a CNT_CLR pulse.
REQ-030 Without STOPWATCH_CTRL_AUTOSTOP_EN, the comparator and OVFSTOP SHALL be absent, and STATE SHALL never show the OVFSTOP code.

Structure
REQ-031 stopwatch_pkg SHALL hold the state enum, the NDIG default, and the OVF_PATTERN constant (5,9,5,9,9,9).
REQ-032 One sub-module, sw_lap_latch, SHALL hold the capture register and DISP_OUT multiplexer (inputs: capture, hold, DIG_IN).
REQ-033 The FSM and CNT_CLR register SHALL stay in stopwatch_ctrl.

Verification
REQ-034 Reset, SS, 100 EN10MS ticks, SS -> exactly 100 CNT_TICK pulses; STATE=PAUSE; RUN_LED 0.
REQ-035 In RUN with DIG_IN=00:12.34, LR; then DIG_IN advances to 00:15.00 -> DISP_OUT holds 00:12.34; second LR -> DISP_OUT=00:15.00.
REQ-036 PAUSE, LR -> one-cycle CNT_CLR exactly one cycle after LR; STATE=IDLE; further LR produces no CNT_CLR.
REQ-037 RUN, SS and LR asserted in the same cycle -> STATE=PAUSE, no lap capture, no CNT_CLR.
REQ-038 Macro on, DIG_IN=59:59.99 in RUN -> CNT_TICK low on next EN10MS, STATE=OVFSTOP; SS ignored; LR -> CNT_CLR, IDLE. Macro off -> ticks continue.
REQ-039 RST low during LAP -> STATE=IDLE and DISP_OUT=DIG_IN immediately, with no clock edge.
